// File: rtl/panic_rx_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: frames are released only once their tlast is
// accepted, the byte length is published on a side channel, and frames that overflow are dropped.
module panic_rx_pkt_fifo #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = 64,
    parameter int DEPTH_LOG2      = 6,
    parameter int LEN_FIFO_LOG2   = 4,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [LEN_WIDTH-1:0]       m_len_tdata,
    output logic                       m_len_tvalid,
    input  logic                       m_len_tready,
    output logic [31:0]                drop_count
);

    localparam int DEPTH     = 2 ** DEPTH_LOG2;
    localparam int PTR_W     = DEPTH_LOG2 + 1;
    localparam int LEN_DEPTH = 2 ** LEN_FIFO_LOG2;
    localparam int LPTR_W    = LEN_FIFO_LOG2 + 1;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic [AXIS_KEEP_WIDTH-1:0] keep;
        logic                       last;
    } beat_t;

    function automatic logic [LEN_WIDTH-1:0] popcount(input logic [AXIS_KEEP_WIDTH-1:0] k);
        logic [LEN_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            n = n + LEN_WIDTH'(k[i]);
        end
        return n;
    endfunction

    beat_t                ram [DEPTH];
    logic [LEN_WIDTH-1:0] len_mem [LEN_DEPTH];

    logic                 rst_q;
    logic [PTR_W-1:0]     wr_cur_q, wr_cur_d;
    logic [PTR_W-1:0]     wr_commit_q, wr_commit_d;
    logic [PTR_W-1:0]     rd_q, rd_d;
    logic                 drop_q, drop_d;
    logic [LEN_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]          drop_count_q, drop_count_d;
    logic [LPTR_W-1:0]    len_wr_q, len_wr_d;
    logic [LPTR_W-1:0]    len_rd_q, len_rd_d;
    logic                 out_valid_q, out_valid_d;
    beat_t                out_beat_q, out_beat_d;

    logic                 ram_full;
    logic                 len_full;
    logic                 in_accept;
    logic                 len_pop;
    logic                 beat_drop;
    logic                 ram_we;
    logic                 len_we;
    logic [LEN_WIDTH-1:0] beat_bytes;
    logic [LEN_WIDTH:0]   byte_sum;
    logic [LEN_WIDTH-1:0] byte_sat;

    assign ram_full   = (wr_cur_q - rd_q) == PTR_W'(DEPTH);
    assign len_full   = (len_wr_q - len_rd_q) == LPTR_W'(LEN_DEPTH);
    assign in_accept  = s_axis_tvalid && s_axis_tready;
    assign len_pop    = m_len_tvalid && m_len_tready;
    assign beat_bytes = popcount(s_axis_tkeep);
    assign byte_sum   = {1'b0, byte_cnt_q} + {1'b0, beat_bytes};
    assign byte_sat   = byte_sum[LEN_WIDTH] ? '1 : byte_sum[LEN_WIDTH-1:0];

    // RAM-full never back-pressures the source; it turns the rest of the frame into a drop.
    assign s_axis_tready = !rst_q && !len_full;
    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_beat_q.data;
    assign m_axis_tkeep  = out_beat_q.keep;
    assign m_axis_tlast  = out_beat_q.last;
    assign m_len_tvalid  = len_wr_q != len_rd_q;
    assign m_len_tdata   = len_mem[len_rd_q[LEN_FIFO_LOG2-1:0]];
    assign drop_count    = drop_count_q;

    always_comb begin
        // NOTE: every _d and strobe takes a default first so no path leaves it unassigned (no latch).
        wr_cur_d     = wr_cur_q;
        wr_commit_d  = wr_commit_q;
        drop_d       = drop_q;
        byte_cnt_d   = byte_cnt_q;
        drop_count_d = drop_count_q;
        beat_drop    = 1'b0;
        ram_we       = 1'b0;
        len_we       = 1'b0;

        if (in_accept) begin
            beat_drop = drop_q || ram_full;
            if (!beat_drop) begin
                ram_we     = 1'b1;
                wr_cur_d   = wr_cur_q + PTR_W'(1);
                byte_cnt_d = byte_sat;
            end
            if (s_axis_tlast) begin
                byte_cnt_d = '0;
                drop_d     = 1'b0;
                if (beat_drop) begin
                    wr_cur_d     = wr_commit_q;
                    drop_count_d = (drop_count_q == '1) ? drop_count_q : drop_count_q + 32'd1;
                end else begin
                    wr_commit_d = wr_cur_q + PTR_W'(1);
                    len_we      = 1'b1;
                end
            end else if (beat_drop) begin
                drop_d = 1'b1;
            end
        end
    end

    // Output register refills whenever it is empty or being consumed, giving full-rate streaming.
    always_comb begin
        rd_d        = rd_q;
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        if ((rd_q != wr_commit_q) && (!out_valid_q || m_axis_tready)) begin
            rd_d        = rd_q + PTR_W'(1);
            out_valid_d = 1'b1;
            out_beat_d  = ram[rd_q[DEPTH_LOG2-1:0]];
        end else if (m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    assign len_wr_d = len_wr_q + LPTR_W'(len_we);
    assign len_rd_d = len_rd_q + LPTR_W'(len_pop);

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            wr_cur_q     <= '0;
            wr_commit_q  <= '0;
            rd_q         <= '0;
            drop_q       <= 1'b0;
            byte_cnt_q   <= '0;
            drop_count_q <= '0;
            len_wr_q     <= '0;
            len_rd_q     <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            wr_cur_q     <= wr_cur_d;
            wr_commit_q  <= wr_commit_d;
            rd_q         <= rd_d;
            drop_q       <= drop_d;
            byte_cnt_q   <= byte_cnt_d;
            drop_count_q <= drop_count_d;
            len_wr_q     <= len_wr_d;
            len_rd_q     <= len_rd_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // NOTE: storage and the output payload are not reset; the pointers and valid flags decide what is live.
    always_ff @(posedge clk) begin
        out_beat_q <= out_beat_d;
        if (ram_we) begin
            ram[wr_cur_q[DEPTH_LOG2-1:0]] <= '{data: s_axis_tdata, keep: s_axis_tkeep, last: s_axis_tlast};
        end
        if (len_we) begin
            len_mem[len_wr_q[LEN_FIFO_LOG2-1:0]] <= byte_sat;
        end
    end

endmodule

// File: tb/tb_panic_rx_pkt_fifo.sv
// Self-checking bench for panic_rx_pkt_fifo: directed latency/overflow/reset steps plus a
// randomized run scored against a frame-level reference model.
module tb_panic_rx_pkt_fifo;

    localparam int DW    = 512;
    localparam int KW    = 64;
    localparam int DEPTH = 64;
    localparam int LW    = 16;

    typedef logic [DW+KW:0] beat_t;  // {data, keep, last}

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [LW-1:0] m_len_tdata;
    logic          m_len_tvalid;
    logic          m_len_tready;
    logic [31:0]   drop_count;

    always #5 clk = ~clk;

    panic_rx_pkt_fifo #(
        .AXIS_DATA_WIDTH(DW),
        .AXIS_KEEP_WIDTH(KW),
        .DEPTH_LOG2     (6),
        .LEN_FIFO_LOG2  (4),
        .LEN_WIDTH      (LW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast (s_axis_tlast),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .m_len_tdata  (m_len_tdata),
        .m_len_tvalid (m_len_tvalid),
        .m_len_tready (m_len_tready),
        .drop_count   (drop_count)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t exp_beats[$];
    int    exp_lens[$];
    beat_t cur_frame[$];
    int    exp_drops   = 0;
    bit    drop_next   = 1'b0;
    bit    rand_mode   = 1'b0;
    bit    s_acc       = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input beat_t obs, input beat_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [KW-1:0] keep_mask(input int nbytes);
        logic [KW-1:0] m;
        for (int j = 0; j < KW; j++) m[j] = (j < nbytes);
        return m;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Frame-level reference: a frame either arrives whole with its byte total, or is dropped.
    task automatic model_in(input beat_t b);
        int len;
        int n;
        cur_frame.push_back(b);
        if (b[0]) begin
            len = 0;
            n   = cur_frame.size();
            foreach (cur_frame[i]) len += $countones(cur_frame[i][KW:1]);
            if (n > DEPTH || drop_next) begin
                exp_drops++;
                drop_next = 1'b0;
            end else begin
                foreach (cur_frame[i]) exp_beats.push_back(cur_frame[i]);
                exp_lens.push_back(len);
            end
            cur_frame.delete();
        end
    endtask

    // One clock: sample handshakes 2 time units after the previous edge, then advance.
    task automatic cycle();
        beat_t obs;
        if (rand_mode) begin
            m_axis_tready = ($urandom_range(0, 3) != 0);
            m_len_tready  = ($urandom_range(0, 3) != 0);
        end
        #1;
        s_acc = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            check("beat_expected", 32'(exp_beats.size() != 0), 32'd1);
            obs = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            if (exp_beats.size() != 0) check_beat("out_beat", obs, exp_beats.pop_front());
        end
        if (m_len_tvalid && m_len_tready) begin
            check("len_expected", 32'(exp_lens.size() != 0), 32'd1);
            if (exp_lens.size() != 0) check("out_len", 32'(m_len_tdata), 32'(exp_lens.pop_front()));
        end
        if (s_acc) model_in({s_axis_tdata, s_axis_tkeep, s_axis_tlast});
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        int b;
        if (rand_mode) begin
            while ($urandom_range(0, 3) == 0) cycle();
        end
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        b = 0;
        do begin
            cycle();
            b++;
        end while (!s_acc && b < 200);
        s_axis_tvalid = 1'b0;
        check("s_accept", 32'(s_acc), 32'd1);
    endtask

    task automatic send_frame(input int n, input int last_bytes);
        for (int i = 0; i < n; i++) begin
            send_beat(rand_data(), (i == n - 1) ? keep_mask(last_bytes) : '1, i == n - 1);
        end
    endtask

    task automatic drain();
        int b;
        rand_mode     = 1'b0;
        m_axis_tready = 1'b1;
        m_len_tready  = 1'b1;
        b = 0;
        while ((exp_beats.size() != 0 || exp_lens.size() != 0) && b < 3000) begin
            cycle();
            b++;
        end
        check("drain_complete", 32'(exp_beats.size() + exp_lens.size()), 32'd0);
        repeat (3) cycle();
        check("no_extra_beat", 32'(m_axis_tvalid), 32'd0);
        check("no_extra_len", 32'(m_len_tvalid), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int b;
        b = 0;
        while (!s_axis_tready && b < 10) begin
            cycle();
            b++;
        end
        check(tag, 32'(s_axis_tready), 32'd1);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int n;
        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        m_len_tready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_len_tvalid", 32'(m_len_tvalid), 32'd0);
        check("rst_drop_count", drop_count, 32'd0);
        rst = 1'b0;
        wait_ready("tready_after_reset");

        // 1) 3-beat frame, latency of length and data
        m_axis_tready = 1'b1;
        m_len_tready  = 1'b0;
        send_beat(rand_data(), '1, 1'b0);
        send_beat(rand_data(), '1, 1'b0);
        send_beat(rand_data(), keep_mask(4), 1'b1);
        check("t1_len_valid_n1", 32'(m_len_tvalid), 32'd1);
        check("t1_len_132", 32'(m_len_tdata), 32'd132);
        check("t1_data_idle_n1", 32'(m_axis_tvalid), 32'd0);
        cycle();
        check("t1_beat1_valid_n2", 32'(m_axis_tvalid), 32'd1);
        check("t1_beat1_last", 32'(m_axis_tlast), 32'd0);
        cycle();
        check("t1_beat2_valid_n3", 32'(m_axis_tvalid), 32'd1);
        check("t1_beat2_last", 32'(m_axis_tlast), 32'd0);
        cycle();
        check("t1_beat3_valid_n4", 32'(m_axis_tvalid), 32'd1);
        check("t1_beat3_last", 32'(m_axis_tlast), 32'd1);
        cycle();
        check("t1_idle_n5", 32'(m_axis_tvalid), 32'd0);
        check("t1_drop_count", drop_count, 32'd0);
        drain();

        // 2) Fill the RAM with output stalled; the fifth frame overflows
        m_axis_tready = 1'b0;
        m_len_tready  = 1'b0;
        repeat (4) send_frame(16, 64);
        drop_next = 1'b1;
        send_frame(8, 64);
        repeat (2) cycle();
        check("t2_drop_count", drop_count, 32'(exp_drops));
        check("t2_drop_is_1", drop_count, 32'd1);
        check("t2_len_valid", 32'(m_len_tvalid), 32'd1);
        check("t2_len_1024", 32'(m_len_tdata), 32'd1024);
        check("t2_exp_len_entries", 32'(exp_lens.size()), 32'd4);
        check("t2_s_tready", 32'(s_axis_tready), 32'd1);
        check("t2_out_held", 32'(m_axis_tvalid), 32'd1);
        drain();

        // 3) Oversized frame dropped, next frame intact
        m_len_tready = 1'b0;
        send_frame(70, 64);
        send_frame(2, 64);
        check("t3_len_valid", 32'(m_len_tvalid), 32'd1);
        check("t3_len_128", 32'(m_len_tdata), 32'd128);
        check("t3_drop_count", drop_count, 32'd2);
        drain();

        // 4) Length FIFO full stalls the input
        m_axis_tready = 1'b1;
        m_len_tready  = 1'b0;
        send_frame(1, 0);
        for (int i = 1; i < 16; i++) begin
            send_frame(1, $urandom_range(0, 64));
            if (i == 14) check("t4_ready_after_15", 32'(s_axis_tready), 32'd1);
        end
        check("t4_not_ready_after_16", 32'(s_axis_tready), 32'd0);
        m_len_tready = 1'b1;
        cycle();
        m_len_tready = 1'b0;
        check("t4_ready_after_pop", 32'(s_axis_tready), 32'd1);
        drain();

        // 5) Randomized traffic with backpressure on every channel
        rand_mode = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            if (f % 50 == 49) begin
                n = $urandom_range(65, 70);
            end else begin
                int b;
                n = $urandom_range(1, 20);
                b = 0;
                while (exp_beats.size() + n > DEPTH && b < 2000) begin
                    cycle();
                    b++;
                end
            end
            send_frame(n, $urandom_range(0, 64));
        end
        drain();
        check("t5_drop_count", drop_count, 32'(exp_drops));

        // 6) Reset in the middle of traffic on both sides
        m_axis_tready = 1'b0;
        m_len_tready  = 1'b0;
        send_frame(2, 64);
        send_beat(rand_data(), '1, 1'b0);
        send_beat(rand_data(), '1, 1'b0);
        repeat (3) cycle();
        check("t6_pre_out_valid", 32'(m_axis_tvalid), 32'd1);
        check("t6_pre_drop_count", drop_count, 32'(exp_drops));
        s_axis_tdata  = rand_data();
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        check("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t6_len_tvalid", 32'(m_len_tvalid), 32'd0);
        check("t6_s_tready", 32'(s_axis_tready), 32'd0);
        check("t6_drop_count", drop_count, 32'd0);
        exp_beats.delete();
        exp_lens.delete();
        cur_frame.delete();
        exp_drops     = 0;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        wait_ready("t6_tready_after_reset");
        m_len_tready = 1'b0;
        send_frame(3, 17);
        check("t6_len_valid", 32'(m_len_tvalid), 32'd1);
        check("t6_len_145", 32'(m_len_tdata), 32'd145);
        drain();
        check("t6_final_drop_count", drop_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
